// File: rtl/pipeline_dest_tracker_if.sv
// Bundle of EX/ID-side inputs and tracker outputs for pipeline_dest_tracker.
//   master : pipeline control (drives EX/ID fields, reads tracked state/selects)
//   slave  : the tracker itself
// Fields: ex_wr_addr/ex_reg_write/ex_mem_read/ex_rs/ex_rt (EX instr),
//         id_rs/id_rt/id_uses_rs/id_uses_rt (ID instr),
//         mem_*/wb_* (tracked destinations), fwd_a/fwd_b, stall,
//         id_byp_rs/id_byp_rt, stall_cnt.
interface pipeline_dest_tracker_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] ex_wr_addr;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [ADDR_W-1:0] ex_rs;
    logic [ADDR_W-1:0] ex_rt;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              mem_reg_write;
    logic [ADDR_W-1:0] wb_wr_addr;
    logic              wb_reg_write;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;
    logic              id_byp_rs;
    logic              id_byp_rt;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output ex_wr_addr, ex_reg_write, ex_mem_read, ex_rs, ex_rt,
               id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  mem_wr_addr, mem_reg_write, wb_wr_addr, wb_reg_write,
               fwd_a, fwd_b, stall, id_byp_rs, id_byp_rt, stall_cnt
    );

    modport slave (
        input  ex_wr_addr, ex_reg_write, ex_mem_read, ex_rs, ex_rt,
               id_rs, id_rt, id_uses_rs, id_uses_rt,
        output mem_wr_addr, mem_reg_write, wb_wr_addr, wb_reg_write,
               fwd_a, fwd_b, stall, id_byp_rs, id_byp_rt, stall_cnt
    );
endinterface

// File: rtl/pipeline_dest_tracker.sv
// Carries the EX destination register (and its write-enable) through EX/MEM and
// MEM/WB, and derives ALU forwarding selects, the ID load-use stall, the ID
// register-file write-through bypass and a saturating stall-cycle counter.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pipeline_dest_tracker_if.slave (EX/ID inputs, tracked state, selects)
module pipeline_dest_tracker #(
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 16,
    parameter int WB_BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_dest_tracker_if.slave  bus
);
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } dest_t;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    dest_t            mem_q;
    dest_t            wb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ex_we;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // A write to $0 is squashed here, so nothing downstream ever sees it as live.
    assign ex_we = bus.ex_reg_write & (bus.ex_wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= '{we: ex_we, addr: bus.ex_wr_addr};
            wb_q  <= mem_q;
            if (stall && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // MEM is checked first: it holds the younger result.
    always_comb begin
        fwd_a = FWD_IDEX;
        if (mem_q.we && (mem_q.addr == bus.ex_rs))
            fwd_a = FWD_EXMEM;
        else if (wb_q.we && (wb_q.addr == bus.ex_rs))
            fwd_a = FWD_MEMWB;
    end

    always_comb begin
        fwd_b = FWD_IDEX;
        if (mem_q.we && (mem_q.addr == bus.ex_rt))
            fwd_b = FWD_EXMEM;
        else if (wb_q.we && (wb_q.addr == bus.ex_rt))
            fwd_b = FWD_MEMWB;
    end

    // Load in EX whose result the ID instr needs next cycle: one bubble covers it.
    assign stall = bus.ex_mem_read & ex_we &
                   ((bus.id_uses_rs & (bus.id_rs == bus.ex_wr_addr)) |
                    (bus.id_uses_rt & (bus.id_rt == bus.ex_wr_addr)));

    generate
        if (WB_BYPASS != 0) begin : g_byp
            assign bus.id_byp_rs = wb_q.we & bus.id_uses_rs & (wb_q.addr == bus.id_rs);
            assign bus.id_byp_rt = wb_q.we & bus.id_uses_rt & (wb_q.addr == bus.id_rt);
        end else begin : g_nobyp
            assign bus.id_byp_rs = 1'b0;
            assign bus.id_byp_rt = 1'b0;
        end
    endgenerate

    assign bus.mem_wr_addr   = mem_q.addr;
    assign bus.mem_reg_write = mem_q.we;
    assign bus.wb_wr_addr    = wb_q.addr;
    assign bus.wb_reg_write  = wb_q.we;
    assign bus.fwd_a         = fwd_a;
    assign bus.fwd_b         = fwd_b;
    assign bus.stall         = stall;
    assign bus.stall_cnt     = cnt_q;
endmodule
